// File: rtl/dm_addr_gen_if.sv
// Sequencer-side and bc_dt bus connections of the data address generator.
// The sequencer/bus side holds the master modport; the generator holds the slave modport.
interface dm_addr_gen_if #(
    parameter int DMA_SIZE = 16,
    parameter int DMD_SIZE = 16
);
    logic                ps_dg_en;
    logic                ps_dg_pre;
    logic [2:0]          ps_dg_ireg;
    logic [2:0]          ps_dg_mreg;
    logic                ps_dg_imm_en;
    logic [DMA_SIZE-1:0] ps_dg_imm;
    logic                ps_dg_wrt_en;
    logic [4:0]          ps_dg_wrt_add;
    logic                ps_dg_rd_en;
    logic [4:0]          ps_dg_rd_add;
    logic [DMD_SIZE-1:0] bc_dt;
    logic [DMA_SIZE-1:0] dg_dm_add;
    logic [DMD_SIZE-1:0] dg_bc_dt;

    modport master (
        output ps_dg_en, ps_dg_pre, ps_dg_ireg, ps_dg_mreg, ps_dg_imm_en, ps_dg_imm,
               ps_dg_wrt_en, ps_dg_wrt_add, ps_dg_rd_en, ps_dg_rd_add, bc_dt,
        input  dg_dm_add, dg_bc_dt
    );

    modport slave (
        input  ps_dg_en, ps_dg_pre, ps_dg_ireg, ps_dg_mreg, ps_dg_imm_en, ps_dg_imm,
               ps_dg_wrt_en, ps_dg_wrt_add, ps_dg_rd_en, ps_dg_rd_add, bc_dt,
        output dg_dm_add, dg_bc_dt
    );
endinterface

// File: rtl/dm_addr_gen.sv
// Data address generator: I/M/L/B register file with pre/post-modify and
// circular-buffer wrap, producing a registered DM address and ureg read-back.
module dm_addr_gen #(
    parameter int DMA_SIZE = 16,
    parameter int DMD_SIZE = 16,
    parameter int NREG     = 8
) (
    input  logic          clk,
    input  logic          reset,
    dm_addr_gen_if.slave  bus
);
    localparam logic [1:0] CLS_I = 2'b00;
    localparam logic [1:0] CLS_M = 2'b01;
    localparam logic [1:0] CLS_L = 2'b10;
    localparam logic [1:0] CLS_B = 2'b11;

    logic [DMA_SIZE-1:0] i_reg [NREG];
    logic [DMA_SIZE-1:0] m_reg [NREG];
    logic [DMA_SIZE-1:0] l_reg [NREG];
    logic [DMA_SIZE-1:0] b_reg [NREG];

    logic [DMA_SIZE-1:0] dm_add_q;
    logic [DMD_SIZE-1:0] bc_dt_q;

    logic [DMA_SIZE-1:0] i_cur;
    logic [DMA_SIZE-1:0] l_cur;
    logic [DMA_SIZE-1:0] b_cur;
    logic [DMA_SIZE-1:0] mod_val;
    logic                mod_neg;
    logic [DMA_SIZE:0]   sum_ext;
    logic [DMA_SIZE:0]   end_ext;
    logic [DMA_SIZE:0]   wrap_ext;
    logic [DMA_SIZE-1:0] wr_val;
    logic [DMA_SIZE-1:0] rd_val;

    always_comb begin
        i_cur   = i_reg[bus.ps_dg_ireg];
        l_cur   = l_reg[bus.ps_dg_ireg];
        b_cur   = b_reg[bus.ps_dg_ireg];
        mod_val = bus.ps_dg_imm_en ? bus.ps_dg_imm : m_reg[bus.ps_dg_mreg];
        mod_neg = mod_val[DMA_SIZE-1];
        // Sign-extended add on one extra bit so the wrap compares see the carry.
        sum_ext = {1'b0, i_cur} + {mod_neg, mod_val};
        end_ext = {1'b0, b_cur} + {1'b0, l_cur};
        wrap_ext = sum_ext;
        if (l_cur != '0) begin
            if (!mod_neg && (sum_ext >= end_ext)) begin
                wrap_ext = sum_ext - {1'b0, l_cur};
            end else if (mod_neg && (sum_ext < {1'b0, b_cur})) begin
                wrap_ext = sum_ext + {1'b0, l_cur};
            end
        end
    end

    always_comb begin
        wr_val = DMA_SIZE'(bus.bc_dt);
        rd_val = '0;
        case (bus.ps_dg_rd_add[4:3])
            CLS_I:   rd_val = i_reg[bus.ps_dg_rd_add[2:0]];
            CLS_M:   rd_val = m_reg[bus.ps_dg_rd_add[2:0]];
            CLS_L:   rd_val = l_reg[bus.ps_dg_rd_add[2:0]];
            default: rd_val = b_reg[bus.ps_dg_rd_add[2:0]];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NREG; k++) begin
                i_reg[k] <= '0;
                m_reg[k] <= '0;
                l_reg[k] <= '0;
                b_reg[k] <= '0;
            end
            dm_add_q <= '0;
            bc_dt_q  <= '0;
        end else begin
            if (bus.ps_dg_en) begin
                if (bus.ps_dg_pre) begin
                    dm_add_q <= sum_ext[DMA_SIZE-1:0];
                end else begin
                    dm_add_q              <= i_cur;
                    i_reg[bus.ps_dg_ireg] <= wrap_ext[DMA_SIZE-1:0];
                end
            end
            // Placed after the access update so a same-cycle ureg write to I wins.
            if (bus.ps_dg_wrt_en) begin
                case (bus.ps_dg_wrt_add[4:3])
                    CLS_I: i_reg[bus.ps_dg_wrt_add[2:0]] <= wr_val;
                    CLS_M: m_reg[bus.ps_dg_wrt_add[2:0]] <= wr_val;
                    CLS_L: l_reg[bus.ps_dg_wrt_add[2:0]] <= wr_val;
                    default: begin
                        b_reg[bus.ps_dg_wrt_add[2:0]] <= wr_val;
                        i_reg[bus.ps_dg_wrt_add[2:0]] <= wr_val;
                    end
                endcase
            end
            if (bus.ps_dg_rd_en) begin
                bc_dt_q <= DMD_SIZE'(rd_val);
            end
        end
    end

    assign bus.dg_dm_add = dm_add_q;
    assign bus.dg_bc_dt  = bc_dt_q;
endmodule

// File: tb/tb_dm_addr_gen.sv
// Self-checking bench for dm_addr_gen: expected addresses and read data are queued
// when stimulus is driven and compared when the registered outputs appear.
module tb_dm_addr_gen;
    localparam logic [1:0] CI = 2'd0;
    localparam logic [1:0] CM = 2'd1;
    localparam logic [1:0] CL = 2'd2;
    localparam logic [1:0] CB = 2'd3;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    logic [15:0] add_q [$];
    logic [15:0] rd_q [$];

    dm_addr_gen_if #(.DMA_SIZE(16), .DMD_SIZE(16)) bus ();

    dm_addr_gen #(.DMA_SIZE(16), .DMD_SIZE(16), .NREG(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ps_dg_en      = 1'b0;
        bus.ps_dg_pre     = 1'b0;
        bus.ps_dg_ireg    = 3'd0;
        bus.ps_dg_mreg    = 3'd0;
        bus.ps_dg_imm_en  = 1'b0;
        bus.ps_dg_imm     = 16'h0;
        bus.ps_dg_wrt_en  = 1'b0;
        bus.ps_dg_wrt_add = 5'd0;
        bus.ps_dg_rd_en   = 1'b0;
        bus.ps_dg_rd_add  = 5'd0;
        bus.bc_dt         = 16'h0;
    endtask

    task automatic pop_add(input string tag);
        if (add_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty, got 0x%0h", tag, bus.dg_dm_add);
        end else begin
            chk(tag, 32'(bus.dg_dm_add), 32'(add_q.pop_front()));
        end
    endtask

    task automatic pop_rd(input string tag);
        if (rd_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty, got 0x%0h", tag, bus.dg_bc_dt);
        end else begin
            chk(tag, 32'(bus.dg_bc_dt), 32'(rd_q.pop_front()));
        end
    endtask

    task automatic set_acc(input logic pre, input logic [2:0] ireg, input logic [2:0] mreg,
                           input logic imm_en, input logic [15:0] imm);
        bus.ps_dg_en     = 1'b1;
        bus.ps_dg_pre    = pre;
        bus.ps_dg_ireg   = ireg;
        bus.ps_dg_mreg   = mreg;
        bus.ps_dg_imm_en = imm_en;
        bus.ps_dg_imm    = imm;
    endtask

    task automatic wr(input logic [1:0] cls, input logic [2:0] n, input logic [15:0] data);
        bus.ps_dg_wrt_en  = 1'b1;
        bus.ps_dg_wrt_add = {cls, n};
        bus.bc_dt         = data;
        step();
        idle();
    endtask

    task automatic rd(input string tag, input logic [1:0] cls, input logic [2:0] n,
                      input logic [15:0] exp);
        bus.ps_dg_rd_en  = 1'b1;
        bus.ps_dg_rd_add = {cls, n};
        rd_q.push_back(exp);
        step();
        idle();
        pop_rd(tag);
    endtask

    task automatic acc(input string tag, input logic pre, input logic [2:0] ireg,
                       input logic [2:0] mreg, input logic imm_en, input logic [15:0] imm,
                       input logic [15:0] exp);
        set_acc(pre, ireg, mreg, imm_en, imm);
        add_q.push_back(exp);
        step();
        idle();
        pop_add(tag);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        idle();
        step();
        step();
        chk("reset_add", 32'(bus.dg_dm_add), 32'h0);
        chk("reset_bc", 32'(bus.dg_bc_dt), 32'h0);
        reset = 1'b0;
        step();

        // Reset mid-access
        wr(CI, 3'd0, 16'h1234);
        wr(CM, 3'd0, 16'h0010);
        acc("pre_rst_acc", 1'b0, 3'd0, 3'd0, 1'b0, 16'h0, 16'h1234);
        rd("pre_rst_rd", CI, 3'd0, 16'h1244);
        set_acc(1'b0, 3'd0, 3'd0, 1'b0, 16'h0);
        bus.ps_dg_rd_en  = 1'b1;
        bus.ps_dg_rd_add = {CM, 3'd0};
        #2 reset = 1'b1;
        #1;
        chk("midrst_add", 32'(bus.dg_dm_add), 32'h0);
        chk("midrst_bc", 32'(bus.dg_bc_dt), 32'h0);
        step();
        idle();
        #2 reset = 1'b0;
        step();
        for (int c = 0; c < 4; c++) begin
            for (int n = 0; n < 8; n++) begin
                rd($sformatf("rst_reg_%0d_%0d", c, n), 2'(c), 3'(n), 16'h0);
            end
        end
        acc("first_after_rst", 1'b0, 3'd0, 3'd0, 1'b0, 16'h0, 16'h0000);
        rd("first_after_rst_i0", CI, 3'd0, 16'h0000);

        // Linear post-modify
        wr(CI, 3'd2, 16'h0100);
        wr(CM, 3'd1, 16'h0004);
        wr(CL, 3'd2, 16'h0000);
        acc("lin_0", 1'b0, 3'd2, 3'd1, 1'b0, 16'h0, 16'h0100);
        acc("lin_1", 1'b0, 3'd2, 3'd1, 1'b0, 16'h0, 16'h0104);
        acc("lin_2", 1'b0, 3'd2, 3'd1, 1'b0, 16'h0, 16'h0108);
        rd("lin_i2", CI, 3'd2, 16'h010C);

        // Circular buffer
        wr(CB, 3'd3, 16'h0200);
        rd("circ_i3_restart", CI, 3'd3, 16'h0200);
        wr(CL, 3'd3, 16'h0005);
        acc("circ_0", 1'b0, 3'd3, 3'd0, 1'b1, 16'h0002, 16'h0200);
        acc("circ_1", 1'b0, 3'd3, 3'd0, 1'b1, 16'h0002, 16'h0202);
        acc("circ_2", 1'b0, 3'd3, 3'd0, 1'b1, 16'h0002, 16'h0204);
        acc("circ_3", 1'b0, 3'd3, 3'd0, 1'b1, 16'h0002, 16'h0201);
        rd("circ_i3_fwd", CI, 3'd3, 16'h0203);
        wr(CI, 3'd3, 16'h0201);
        acc("circ_neg", 1'b0, 3'd3, 3'd0, 1'b1, 16'hFFFD, 16'h0201);
        rd("circ_neg_i3", CI, 3'd3, 16'h0203);
        acc("circ_end", 1'b0, 3'd3, 3'd0, 1'b1, 16'h0002, 16'h0203);
        rd("circ_end_i3", CI, 3'd3, 16'h0200);
        wr(CI, 3'd3, 16'h0202);
        acc("circ_base", 1'b0, 3'd3, 3'd0, 1'b1, 16'hFFFE, 16'h0202);
        rd("circ_base_i3", CI, 3'd3, 16'h0200);

        // Pre-modify
        wr(CI, 3'd0, 16'h0010);
        acc("pre_dec", 1'b1, 3'd0, 3'd0, 1'b1, 16'hFFFF, 16'h000F);
        rd("pre_i0_kept", CI, 3'd0, 16'h0010);
        wr(CI, 3'd0, 16'h0000);
        acc("pre_modwrap", 1'b1, 3'd0, 3'd0, 1'b1, 16'hFFFF, 16'hFFFF);
        rd("pre_i0_zero", CI, 3'd0, 16'h0000);

        // Collisions
        wr(CI, 3'd4, 16'h0500);
        wr(CM, 3'd5, 16'h0003);
        set_acc(1'b0, 3'd4, 3'd5, 1'b0, 16'h0);
        bus.ps_dg_wrt_en  = 1'b1;
        bus.ps_dg_wrt_add = {CI, 3'd4};
        bus.bc_dt         = 16'h0777;
        add_q.push_back(16'h0500);
        step();
        idle();
        pop_add("col_i_acc");
        rd("col_i_wins", CI, 3'd4, 16'h0777);
        set_acc(1'b0, 3'd4, 3'd5, 1'b0, 16'h0);
        bus.ps_dg_wrt_en  = 1'b1;
        bus.ps_dg_wrt_add = {CM, 3'd5};
        bus.bc_dt         = 16'h0020;
        add_q.push_back(16'h0777);
        step();
        idle();
        pop_add("col_m_acc");
        rd("col_m_old", CI, 3'd4, 16'h077A);
        acc("col_m_next", 1'b0, 3'd4, 3'd5, 1'b0, 16'h0, 16'h077A);
        rd("col_m_new", CI, 3'd4, 16'h079A);
        set_acc(1'b0, 3'd6, 3'd0, 1'b1, 16'h0001);
        bus.ps_dg_wrt_en  = 1'b1;
        bus.ps_dg_wrt_add = {CB, 3'd6};
        bus.bc_dt         = 16'h0300;
        add_q.push_back(16'h0000);
        step();
        idle();
        pop_add("col_b_acc");
        rd("col_b_i6", CI, 3'd6, 16'h0300);

        // Hold when idle; read-during-write returns old value
        acc("hold_seed", 1'b0, 3'd2, 3'd1, 1'b0, 16'h0, 16'h010C);
        for (int k = 0; k < 3; k++) begin
            bus.ps_dg_ireg = 3'(k + 1);
            bus.ps_dg_imm  = 16'(k * 7 + 1);
            add_q.push_back(16'h010C);
            step();
            pop_add($sformatf("hold_%0d", k));
        end
        idle();
        bus.ps_dg_rd_en   = 1'b1;
        bus.ps_dg_rd_add  = {CB, 3'd3};
        bus.ps_dg_wrt_en  = 1'b1;
        bus.ps_dg_wrt_add = {CB, 3'd3};
        bus.bc_dt         = 16'h0400;
        rd_q.push_back(16'h0200);
        step();
        idle();
        pop_rd("rdw_old_b3");
        rd_q.push_back(16'h0200);
        step();
        pop_rd("rd_hold");
        rd("rdw_new_b3", CB, 3'd3, 16'h0400);
        rd("rdw_new_i3", CI, 3'd3, 16'h0400);
        rd("l3_value", CL, 3'd3, 16'h0005);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
